// File: rtl/alu_seq_pkg.sv
// Shared types for the 16-bit operation sequencer that drives an external 8-bit ALU.
// Holds the command, state and ALU opcode encodings plus the ADD carry helper.
package definitions;

    typedef enum logic [1:0] {
        CMD_ADD16 = 2'b00,
        CMD_LSH16 = 2'b01,
        CMD_RSH16 = 2'b10,
        CMD_CMP16 = 2'b11
    } seq_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FIRST  = 2'b01,
        ST_SECOND = 2'b10,
        ST_DONE   = 2'b11
    } seq_state_e;

    typedef enum logic [2:0] {
        kADD  = 3'd0,
        kLSH  = 3'd1,
        kRSH  = 3'd2,
        kCOMP = 3'd3,
        kCLR  = 3'd4
    } op_mne;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    // The ALU never reports a carry for kADD, so it is recovered from the
    // wrapped sum: a carry happened iff the sum wrapped below the first operand
    // (or landed exactly on it while a carry-in was consumed).
    function automatic logic add_carry(input logic [BYTE_W-1:0] sum,
                                       input logic [BYTE_W-1:0] opa,
                                       input logic             cin);
        return (sum < opa) || (cin && (sum == opa));
    endfunction

endpackage

// File: rtl/alu_seq.sv
// Sequences 16-bit ADD/LSH/RSH/CMP as two byte-wide passes through a shared
// combinational ALU; the ALU itself lives beside this block in the parent.
module alu_seq
    import definitions::*;
(
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                START,
    input  seq_cmd_e            CMD,
    input  logic [WORD_W-1:0]   A,
    input  logic [WORD_W-1:0]   B,
    input  logic                SC_IN,
    output op_mne               ALU_OP,
    output logic [BYTE_W-1:0]   ALU_A,
    output logic [BYTE_W-1:0]   ALU_B,
    output logic                ALU_SC,
    input  logic [BYTE_W-1:0]   ALU_OUT,
    input  logic                ALU_SC_OUT,
    input  logic                ALU_ZERO,
    input  logic                ALU_GREATER,
    output logic [WORD_W-1:0]   RESULT,
    output logic                SC_OUT,
    output logic                EQ,
    output logic                GT,
    output logic                DONE,
    output logic                BUSY
);

    seq_state_e          state;
    seq_state_e          state_next;

    // Operands captured on the accepting edge
    seq_cmd_e            cmd_p0;
    logic [WORD_W-1:0]   a_p0;
    logic [WORD_W-1:0]   b_p0;
    logic                sc_p0;

    // First-pass results
    logic [BYTE_W-1:0]   byte_p1;
    logic                carry_p1;
    logic                zero_hi_p1;
    logic                gt_hi_p1;

    // Second-pass results, committed to the outputs one cycle later
    logic [WORD_W-1:0]   res_p2;
    logic                sc_p2;
    logic                eq_p2;
    logic                gt_p2;

    logic                alu_carry;
    logic                start_ok;

    assign start_ok  = START && (state == ST_IDLE);
    assign alu_carry = add_carry(ALU_OUT, ALU_A, ALU_SC);
    assign BUSY      = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (START) state_next = ST_FIRST;
            ST_FIRST:  state_next = ST_SECOND;
            ST_SECOND: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ALU drive: byte order depends on command (right shift and compare go high byte first)
    always_comb begin
        ALU_OP = kCLR;
        ALU_A  = '0;
        ALU_B  = '0;
        ALU_SC = 1'b0;
        if (state == ST_FIRST) begin
            case (cmd_p0)
                CMD_ADD16: begin
                    ALU_OP = kADD;
                    ALU_A  = a_p0[BYTE_W-1:0];
                    ALU_B  = b_p0[BYTE_W-1:0];
                    ALU_SC = sc_p0;
                end
                CMD_LSH16: begin
                    ALU_OP = kLSH;
                    ALU_A  = a_p0[BYTE_W-1:0];
                    ALU_SC = sc_p0;
                end
                CMD_RSH16: begin
                    ALU_OP = kRSH;
                    ALU_A  = a_p0[WORD_W-1:BYTE_W];
                    ALU_SC = sc_p0;
                end
                default: begin
                    ALU_OP = kCOMP;
                    ALU_A  = a_p0[WORD_W-1:BYTE_W];
                    ALU_B  = b_p0[WORD_W-1:BYTE_W];
                end
            endcase
        end else if (state == ST_SECOND) begin
            case (cmd_p0)
                CMD_ADD16: begin
                    ALU_OP = kADD;
                    ALU_A  = a_p0[WORD_W-1:BYTE_W];
                    ALU_B  = b_p0[WORD_W-1:BYTE_W];
                    ALU_SC = carry_p1;
                end
                CMD_LSH16: begin
                    ALU_OP = kLSH;
                    ALU_A  = a_p0[WORD_W-1:BYTE_W];
                    ALU_SC = carry_p1;
                end
                CMD_RSH16: begin
                    ALU_OP = kRSH;
                    ALU_A  = a_p0[BYTE_W-1:0];
                    ALU_SC = carry_p1;
                end
                default: begin
                    ALU_OP = kCOMP;
                    ALU_A  = a_p0[BYTE_W-1:0];
                    ALU_B  = b_p0[BYTE_W-1:0];
                end
            endcase
        end
    end

    // Operand capture (data only, no reset needed)
    always_ff @(posedge CLK) begin
        if (RESET_N && start_ok) begin
            cmd_p0 <= CMD;
            a_p0   <= A;
            b_p0   <= B;
            sc_p0  <= SC_IN;
        end
        if (state == ST_FIRST) begin
            byte_p1 <= ALU_OUT;
        end
    end

    // First pass: carry/shift-out and high-byte compare flags
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            carry_p1   <= 1'b0;
            zero_hi_p1 <= 1'b0;
            gt_hi_p1   <= 1'b0;
        end else if (state == ST_FIRST) begin
            carry_p1   <= (cmd_p0 == CMD_ADD16) ? alu_carry : ALU_SC_OUT;
            zero_hi_p1 <= ALU_ZERO;
            gt_hi_p1   <= ALU_GREATER;
        end
    end

    // Second pass: assemble the 16-bit word and combined flags
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            res_p2 <= '0;
            sc_p2  <= 1'b0;
            eq_p2  <= 1'b0;
            gt_p2  <= 1'b0;
        end else if (state == ST_SECOND) begin
            case (cmd_p0)
                CMD_ADD16: begin
                    res_p2 <= {ALU_OUT, byte_p1};
                    sc_p2  <= alu_carry;
                end
                CMD_LSH16: begin
                    res_p2 <= {ALU_OUT, byte_p1};
                    sc_p2  <= ALU_SC_OUT;
                end
                CMD_RSH16: begin
                    res_p2 <= {byte_p1, ALU_OUT};
                    sc_p2  <= ALU_SC_OUT;
                end
                default: begin
                    eq_p2 <= zero_hi_p1 && ALU_ZERO;
                    gt_p2 <= zero_hi_p1 ? ALU_GREATER : gt_hi_p1;
                end
            endcase
        end
    end

    // Commit: outputs change only here, so they hold from one DONE to the next
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            RESULT <= '0;
            SC_OUT <= 1'b0;
            EQ     <= 1'b0;
            GT     <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= (state == ST_DONE);
            if (state == ST_DONE) begin
                if (cmd_p0 == CMD_CMP16) begin
                    EQ <= eq_p2;
                    GT <= gt_p2;
                end else begin
                    RESULT <= res_p2;
                    SC_OUT <= sc_p2;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural 8-bit ALU wired beside it.
module tb_alu_seq;
    import definitions::*;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START;
    seq_cmd_e    CMD;
    logic [15:0] A;
    logic [15:0] B;
    logic        SC_IN;
    op_mne       ALU_OP;
    logic [7:0]  ALU_A;
    logic [7:0]  ALU_B;
    logic        ALU_SC;
    logic [7:0]  ALU_OUT;
    logic        ALU_SC_OUT;
    logic        ALU_ZERO;
    logic        ALU_GREATER;
    logic [15:0] RESULT;
    logic        SC_OUT;
    logic        EQ;
    logic        GT;
    logic        DONE;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    alu_seq dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .CMD(CMD), .A(A), .B(B),
        .SC_IN(SC_IN), .ALU_OP(ALU_OP), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_SC(ALU_SC), .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT),
        .ALU_ZERO(ALU_ZERO), .ALU_GREATER(ALU_GREATER), .RESULT(RESULT),
        .SC_OUT(SC_OUT), .EQ(EQ), .GT(GT), .DONE(DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU: kADD reports no carry-out
    always_comb begin
        ALU_OUT    = 8'h00;
        ALU_SC_OUT = 1'b0;
        case (ALU_OP)
            kADD: ALU_OUT = ALU_A + ALU_B + {7'd0, ALU_SC};
            kLSH: begin
                ALU_OUT    = {ALU_A[6:0], ALU_SC};
                ALU_SC_OUT = ALU_A[7];
            end
            kRSH: begin
                ALU_OUT    = {ALU_SC, ALU_A[7:1]};
                ALU_SC_OUT = ALU_A[0];
            end
            default: ALU_OUT = 8'h00;
        endcase
        ALU_ZERO    = (ALU_OP == kCOMP) ? (ALU_A == ALU_B) : (ALU_OUT == 8'h00);
        ALU_GREATER = (ALU_A > ALU_B);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic op_mne first_op(input seq_cmd_e c);
        case (c)
            CMD_ADD16: return kADD;
            CMD_LSH16: return kLSH;
            CMD_RSH16: return kRSH;
            default:   return kCOMP;
        endcase
    endfunction

    task automatic run_op(input string tag, input seq_cmd_e c, input logic [15:0] a,
                          input logic [15:0] b, input logic sc, input logic [15:0] exp_res,
                          input logic exp_sc, input logic exp_eq, input logic exp_gt);
        @(negedge CLK);
        CMD = c; A = a; B = b; SC_IN = sc; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; A = ~a; B = ~b; SC_IN = ~sc;
        chk({tag, "_busy"}, 32'(BUSY), 32'd1);
        chk({tag, "_op1"}, 32'(ALU_OP), 32'(first_op(c)));
        if (c == CMD_LSH16 || c == CMD_RSH16)
            chk({tag, "_alub"}, 32'(ALU_B), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK); #1;
            chk({tag, "_done"}, 32'(DONE), (k == 3) ? 32'd1 : 32'd0);
        end
        chk({tag, "_res"}, 32'(RESULT), 32'(exp_res));
        chk({tag, "_sc"}, 32'(SC_OUT), 32'(exp_sc));
        chk({tag, "_eq"}, 32'(EQ), 32'(exp_eq));
        chk({tag, "_gt"}, 32'(GT), 32'(exp_gt));
        chk({tag, "_idle"}, 32'(BUSY), 32'd0);
        @(posedge CLK); #1;
        chk({tag, "_pulse"}, 32'(DONE), 32'd0);
        chk({tag, "_hold"}, 32'(RESULT), 32'(exp_res));
    endtask

    initial begin
        int ndone;
        RESET_N = 1'b0; START = 1'b1; CMD = CMD_ADD16; A = 16'h1111; B = 16'h2222; SC_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_res", 32'(RESULT), 32'd0);
        chk("rst_flags", {29'd0, SC_OUT, EQ, GT}, 32'd0);
        chk("idle_op", 32'(ALU_OP), 32'(kCLR));
        chk("idle_a", 32'(ALU_A), 32'd0);
        START = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;

        run_op("add_carry8",  CMD_ADD16, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",    CMD_ADD16, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        run_op("add_cin",     CMD_ADD16, 16'h12FF, 16'h00FF, 1'b1, 16'h13FF, 1'b0, 1'b0, 1'b0);
        run_op("lsh",         CMD_LSH16, 16'h8001, 16'h5555, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b0);
        run_op("rsh",         CMD_RSH16, 16'h0181, 16'hAAAA, 1'b1, 16'h80C0, 1'b1, 1'b0, 1'b0);
        run_op("cmp_gt_lo",   CMD_CMP16, 16'h1234, 16'h1200, 1'b0, 16'h80C0, 1'b1, 1'b0, 1'b1);
        run_op("cmp_eq",      CMD_CMP16, 16'hBEEF, 16'hBEEF, 1'b0, 16'h80C0, 1'b1, 1'b1, 1'b0);
        run_op("cmp_gt_hi",   CMD_CMP16, 16'h0100, 16'h00FF, 1'b0, 16'h80C0, 1'b1, 1'b0, 1'b1);
        run_op("cmp_lt",      CMD_CMP16, 16'h00FF, 16'h0100, 1'b0, 16'h80C0, 1'b1, 1'b0, 1'b0);
        run_op("add_flaghold", CMD_ADD16, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);

        // START held high through the whole busy window
        @(negedge CLK);
        CMD = CMD_ADD16; A = 16'h0100; B = 16'h0200; SC_IN = 1'b0; START = 1'b1;
        ndone = 0;
        @(posedge CLK); #1;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) START = 1'b0;
            @(posedge CLK); #1;
            if (DONE) ndone++;
            if (k == 3) chk("rep_res", 32'(RESULT), 32'h0300);
        end
        chk("rep_ndone", ndone, 32'd1);

        // Reset during SECOND abandons the operation
        @(negedge CLK);
        CMD = CMD_ADD16; A = 16'h0F0F; B = 16'h0101; SC_IN = 1'b1; START = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        @(posedge CLK); #1;
        chk("mid_busy", 32'(BUSY), 32'd0);
        chk("mid_res", 32'(RESULT), 32'd0);
        chk("mid_flags", {29'd0, SC_OUT, EQ, GT}, 32'd0);
        @(posedge CLK); #1;
        chk("mid_rst_start", 32'(BUSY), 32'd0);
        START = 1'b0;
        RESET_N = 1'b1;
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK); #1;
            if (DONE) ndone++;
        end
        chk("mid_nodone", ndone, 32'd0);
        chk("mid_idle", 32'(BUSY), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have ports (name direction width meaning): CLK input 1 system clock; RESET_N input 1 reset, synchronous and active-low; one clock only.
REQ-002 SHALL have START input 1, request pulse; CMD input 2, seq_cmd_e; A input 16; B input 16; SC_IN input 1, carry-in/shift-in.
REQ-003 SHALL have ALU_OP output 3, op_mne; ALU_A output 8; ALU_B output 8; ALU_SC output 1. All drive the shared combinational ALU.
REQ-004 SHALL have ALU_OUT input 8, ALU_SC_OUT input 1, ALU_ZERO input 1, ALU_GREATER input 1, all from the ALU.
REQ-005 SHALL have RESULT output 16, SC_OUT output 1, EQ output 1, GT output 1, DONE output 1 (one-cycle pulse), BUSY output 1.

Function
REQ-006 SHALL implement FSM states IDLE, FIRST, SECOND, DONE with transitions IDLE->FIRST->SECOND->DONE->IDLE.
- IDLE->FIRST only on START=1.
- All other transitions are unconditional.
REQ-007 SHALL latch CMD, A, B and SC_IN on the accepting edge; START SHALL be ignored in every state except IDLE.
REQ-008 SHALL have a fixed latency: START accepted at edge N, DONE=1 in the cycle after edge N+3, RESULT/SC_OUT/EQ/GT valid in that same cycle.
REQ-009 SHALL hold RESULT, SC_OUT, EQ and GT stable from DONE until the next DONE.
REQ-010 SHALL drive BUSY=1 in FIRST, SECOND and DONE; BUSY SHALL be 0 in IDLE.
REQ-011 SHALL drive ALU_* combinationally from state and latched operands. In IDLE and DONE: ALU_OP=kCLR, ALU_A=0, ALU_B=0, ALU_SC=0.
REQ-012 SHALL sequence ADD16 as follows.
- FIRST: kADD on low bytes, ALU_SC = latched SC_IN.
- SECOND: kADD on high bytes, ALU_SC = carry from the low byte.
REQ-013 SHALL compute the ADD carry internally, because the ALU reports SC_OUT=0 for kADD: carry = (ALU_OUT < ALU_A) OR (ALU_SC AND ALU_OUT == ALU_A), unsigned. The final SC_OUT is the high-byte carry.
REQ-014 SHALL sequence LSH16 as follows.
- FIRST: kLSH on A low byte, ALU_SC = SC_IN.
- SECOND: kLSH on A high byte, ALU_SC = captured ALU_SC_OUT from FIRST.
- SC_OUT = ALU_SC_OUT from SECOND.
REQ-015 SHALL sequence RSH16 high byte first.
- FIRST: kRSH on A high byte, ALU_SC = SC_IN.
- SECOND: kRSH on A low byte, ALU_SC = captured ALU_SC_OUT from FIRST.
- SC_OUT = ALU_SC_OUT from SECOND.
REQ-016 SHALL sequence CMP16 (unsigned) high byte first with kCOMP.
- EQ = ZERO_hi AND ZERO_lo.
- GT = ZERO_hi ? GREATER_lo : GREATER_hi.
- RESULT and SC_OUT are unchanged.
- The low-byte compare SHALL always execute (fixed latency).
REQ-017 SHALL hold EQ and GT unchanged for non-compare commands; ALU_B SHALL be 0 for shift commands.
REQ-018 SHALL wrap ADD16 modulo 2^16, e.g. 0xFFFF+0x0001 gives 0x0000 with SC_OUT=1.

Reset
REQ-019 SHALL, on RESET_N=0 at a CLK edge, go to IDLE with RESULT=0, SC_OUT=0, EQ=0, GT=0, DONE=0, BUSY=0, and clear all internal carry/flag registers.
REQ-020 SHALL abandon any in-flight operation when reset occurs mid-operation; no DONE SHALL follow, and START SHALL be ignored while RESET_N=0.

Structure
REQ-021 SHALL define seq_cmd_e in package definitions: CMD_ADD16=2'b00, CMD_LSH16=2'b01, CMD_RSH16=2'b10, CMD_CMP16=2'b11.
REQ-022 SHALL define seq_state_e in package definitions, and SHALL reuse the existing op_mne values kADD, kLSH, kRSH, kCOMP, kCLR.
REQ-023 SHALL NOT instantiate any sub-module; the ALU SHALL be instantiated beside alu_seq in the parent and wired through the ALU_* ports.

Verification
REQ-024 ADD16 A=0x00FF, B=0x0001, SC_IN=0 -> RESULT=0x0100, SC_OUT=0, DONE at cycle 4 after START.
REQ-025 ADD16 A=0xFFFF, B=0x0001 -> RESULT=0x0000, SC_OUT=1; ADD16 A=0x12FF, B=0x00FF, SC_IN=1 -> RESULT=0x13FF, SC_OUT=0.
REQ-026 LSH16 A=0x8001, SC_IN=1 -> RESULT=0x0003, SC_OUT=1; RSH16 A=0x0181, SC_IN=1 -> RESULT=0x80C0, SC_OUT=1.
REQ-027 CMP16 A=0x1234, B=0x1200 -> EQ=0, GT=1; A=B=0xBEEF -> EQ=1, GT=0; A=0x0100, B=0x00FF -> EQ=0, GT=1.
REQ-028 START re-pulsed during BUSY -> ignored, exactly one DONE; RESET_N=0 in SECOND -> IDLE next cycle, no DONE, all outputs 0.
